// File: rtl/auth_attempt_ctrl.sv
// auth_attempt_ctrl: turns comparator match/mismatch levels into single
// attempts, opens the lock for a fixed window on a pass, counts consecutive
// failures and imposes a timed lockout with a one-cycle alarm pulse.
module auth_attempt_ctrl #(
  parameter int MAX_FAIL    = 3,
  parameter int FAIL_W      = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              matched,
  input  logic              unmatched,
  output logic              unlock,
  output logic              locked,
  output logic              alarm,
  output logic [FAIL_W-1:0] fail_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_OPEN   = 2'b01,
    S_LOCKED = 2'b10
  } state_t;

  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W:0]    MAX_EXT   = (FAIL_W + 1)'(MAX_FAIL);

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0]   fail_count_q, fail_count_d;
  logic                press_prev_q;
  logic                unlock_q, unlock_d;
  logic                locked_q, locked_d;
  logic                alarm_q, alarm_d;

  logic                press_s;
  logic                evt_s;
  logic                pass_s;
  logic [FAIL_W:0]     fail_inc_s;

  assign press_s    = matched | unmatched;
  assign evt_s      = press_s & ~press_prev_q;
  assign pass_s     = matched & ~unmatched;
  // Extra bit so the increment can never wrap before the compare.
  assign fail_inc_s = {1'b0, fail_count_q} + {{FAIL_W{1'b0}}, 1'b1};

  // State, timer, counter and registered outputs; press_prev resets high so
  // a button held through reset release is not seen as a new attempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= {TIMER_W{1'b0}};
      fail_count_q <= {FAIL_W{1'b0}};
      press_prev_q <= 1'b1;
      unlock_q     <= 1'b0;
      locked_q     <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fail_count_q <= fail_count_d;
      press_prev_q <= press_s;
      unlock_q     <= unlock_d;
      locked_q     <= locked_d;
      alarm_q      <= alarm_d;
    end
  end

  // Next-state, timer and failure-count logic; events only matter in IDLE.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fail_count_d = fail_count_q;
    case (state_q)
      S_IDLE: begin
        if (evt_s) begin
          if (pass_s) begin
            state_d      = S_OPEN;
            timer_d      = OPEN_LOAD;
            fail_count_d = {FAIL_W{1'b0}};
          end else if (fail_inc_s >= MAX_EXT) begin
            state_d      = S_LOCKED;
            timer_d      = LOCK_LOAD;
            fail_count_d = MAX_EXT[FAIL_W-1:0];
          end else begin
            fail_count_d = fail_inc_s[FAIL_W-1:0];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (timer_q == {TIMER_W{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
        end
      end
      S_LOCKED: begin
        if (timer_q == {TIMER_W{1'b0}}) begin
          state_d      = S_IDLE;
          fail_count_d = {FAIL_W{1'b0}};
        end else begin
          timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d      = S_IDLE;
        timer_d      = {TIMER_W{1'b0}};
        fail_count_d = {FAIL_W{1'b0}};
      end
    endcase
  end

  // Output decode from the upcoming state so outputs are registered yet
  // change on the same edge as the state; alarm marks only the entry edge.
  always_comb begin
    unlock_d = 1'b0;
    locked_d = 1'b0;
    alarm_d  = 1'b0;
    case (state_d)
      S_OPEN:   unlock_d = 1'b1;
      S_LOCKED: begin
        locked_d = 1'b1;
        alarm_d  = (state_q != S_LOCKED);
      end
      default: begin
        unlock_d = 1'b0;
        locked_d = 1'b0;
      end
    endcase
  end

  assign unlock     = unlock_q;
  assign locked     = locked_q;
  assign alarm      = alarm_q;
  assign fail_count = fail_count_q;

endmodule
